// File: rtl/idex_stage_r32i_if.sv
// Bundle between the ID/EX stage, its instruction source, the register file
// and the ALU. The slave modport is the stage's view; master is the driver's.
interface idex_stage_r32i_if #(
    parameter int dataW    = 32,
    parameter int regAddrW = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr;
    logic [regAddrW-1:0] rs1_addr;
    logic [regAddrW-1:0] rs2_addr;
    logic [dataW-1:0]    rs1_data;
    logic [dataW-1:0]    rs2_data;
    logic                fwd_we;
    logic [regAddrW-1:0] fwd_rd;
    logic [dataW-1:0]    fwd_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [dataW-1:0]    A;
    logic [dataW-1:0]    B;
    logic [3:0]          alucode;
    logic [regAddrW-1:0] rd;
    logic                we;
    logic                illegal;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data,
               flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, A, B, alucode, rd, we,
               illegal
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data,
               flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, A, B, alucode, rd, we,
               illegal
    );
endinterface

// File: rtl/idex_stage_r32i.sv
// RV32I decode/issue stage: reads operands with forwarding, decodes OP/OP-IMM/LUI
// into alucodes and holds the result in a single valid/ready output slot.
module idex_stage_r32i #(
    parameter int dataW    = 32,
    parameter int regAddrW = 5
) (
    input logic               clk,
    input logic               rst,
    idex_stage_r32i_if.slave  bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_CPY  = 4'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [regAddrW-1:0] rs1_idx;
    logic [regAddrW-1:0] rs2_idx;
    logic [dataW-1:0]    rs1_val;
    logic [dataW-1:0]    rs2_val;
    logic                load;
    logic                imm_legal;
    logic [dataW-1:0]    d_a;
    logic [dataW-1:0]    d_b;
    logic [3:0]          d_code;
    logic [regAddrW-1:0] d_rd;
    logic                d_we;
    logic                d_ill;

    function automatic logic [3:0] code_for(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign funct7  = bus.instr[31:25];
    assign rs1_idx = bus.instr[19:15];
    assign rs2_idx = bus.instr[24:20];

    assign bus.rs1_addr = rs1_idx;
    assign bus.rs2_addr = rs2_idx;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // x0 always reads zero, so a forward targeting x0 can never win.
    assign rs1_val = (rs1_idx == '0) ? '0 :
                     (bus.fwd_we && bus.fwd_rd == rs1_idx) ? bus.fwd_data : bus.rs1_data;
    assign rs2_val = (rs2_idx == '0) ? '0 :
                     (bus.fwd_we && bus.fwd_rd == rs2_idx) ? bus.fwd_data : bus.rs2_data;

    always_comb begin
        d_a       = '0;
        d_b       = '0;
        d_code    = ALU_ADD;
        d_rd      = '0;
        d_we      = 1'b0;
        d_ill     = 1'b0;
        imm_legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    d_a    = rs1_val;
                    d_b    = (funct3 == 3'b000 && funct7[5]) ? (~rs2_val) + dataW'(1) : rs2_val;
                    d_code = code_for(funct3, funct7[5]);
                    d_rd   = bus.instr[11:7];
                    d_we   = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001)
                    imm_legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    imm_legal = !bus.instr[31] && (bus.instr[29:25] == 5'b00000);
                if (imm_legal) begin
                    d_a    = rs1_val;
                    d_b    = (funct3 == 3'b001 || funct3 == 3'b101) ?
                             {{(dataW-5){1'b0}}, bus.instr[24:20]} :
                             {{(dataW-12){bus.instr[31]}}, bus.instr[31:20]};
                    d_code = code_for(funct3, bus.instr[30]);
                    d_rd   = bus.instr[11:7];
                    d_we   = 1'b1;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                d_b    = {bus.instr[31:12], 12'b0};
                d_code = ALU_CPY;
                d_rd   = bus.instr[11:7];
                d_we   = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    // Flush outranks both load and stall; a stalled slot otherwise holds every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.A         <= '0;
            bus.B         <= '0;
            bus.alucode   <= ALU_ADD;
            bus.rd        <= '0;
            bus.we        <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.A         <= d_a;
            bus.B         <= d_b;
            bus.alucode   <= d_code;
            bus.rd        <= d_rd;
            bus.we        <= d_we;
            bus.illegal   <= d_ill;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_idex_stage_r32i.sv
// Directed bench for idex_stage_r32i: decode, forwarding, stall, flush and
// reset cases with hand-computed expected slot contents.
module tb_idex_stage_r32i;
    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SLL  = 4'd1;
    localparam logic [3:0] C_SLTU = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_SRL  = 4'd5;
    localparam logic [3:0] C_OR   = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd8;
    localparam logic [3:0] C_CPY  = 4'd9;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    idex_stage_r32i_if #(.dataW(32), .regAddrW(5)) bus ();

    idex_stage_r32i #(.dataW(32), .regAddrW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd_i);
        return {f7, rs2, rs1, f3, rd_i, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd_i);
        return {imm, rs1, f3, rd_i, 7'b0010011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkSlot(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] code,
                             input logic [4:0] rd_e, input logic we_e, input logic ill);
        checkOutput({tag, ".valid"},   32'(bus.out_valid), 32'(v));
        checkOutput({tag, ".A"},       bus.A, a);
        checkOutput({tag, ".B"},       bus.B, b);
        checkOutput({tag, ".alucode"}, 32'(bus.alucode), 32'(code));
        checkOutput({tag, ".rd"},      32'(bus.rd), 32'(rd_e));
        checkOutput({tag, ".we"},      32'(bus.we), 32'(we_e));
        checkOutput({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    endtask

    // Offers one instruction for exactly one edge, then withdraws it.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] r1,
                                 input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.fwd_we    = 1'b0;
        bus.fwd_rd    = '0;
        bus.fwd_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkSlot("reset", 1'b0, 32'h0, 32'h0, C_ADD, 5'd0, 1'b0, 1'b0);
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        bus.instr = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3);
        #1;
        checkOutput("addr.rs1", 32'(bus.rs1_addr), 32'd1);
        checkOutput("addr.rs2", 32'(bus.rs2_addr), 32'd2);

        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
        checkSlot("add", 1'b1, 32'd5, 32'd7, C_ADD, 5'd3, 1'b1, 1'b0);
        applyStimulus(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'd10, 32'd3);
        checkSlot("sub", 1'b1, 32'd10, 32'hFFFF_FFFD, C_ADD, 5'd4, 1'b1, 1'b0);
        applyStimulus(i_type({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd5), 32'h8000_0000, 32'd0);
        checkSlot("srai", 1'b1, 32'h8000_0000, 32'd4, C_SRA, 5'd5, 1'b1, 1'b0);
        applyStimulus(i_type(12'hFFF, 5'd0, 3'b000, 5'd1), 32'd123, 32'd0);
        checkSlot("addi_x0", 1'b1, 32'd0, 32'hFFFF_FFFF, C_ADD, 5'd1, 1'b1, 1'b0);
        applyStimulus(i_type(12'hFFB, 5'd2, 3'b011, 5'd8), 32'd77, 32'd0);
        checkSlot("sltiu", 1'b1, 32'd77, 32'hFFFF_FFFB, C_SLTU, 5'd8, 1'b1, 1'b0);
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b110, 5'd7), 32'hF0, 32'h0F);
        checkSlot("or", 1'b1, 32'hF0, 32'h0F, C_OR, 5'd7, 1'b1, 1'b0);
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b101, 5'd9), 32'd8, 32'd2);
        checkSlot("srl", 1'b1, 32'd8, 32'd2, C_SRL, 5'd9, 1'b1, 1'b0);
        applyStimulus(i_type({7'b0, 5'd3}, 5'd1, 3'b001, 5'd2), 32'd9, 32'd0);
        checkSlot("slli", 1'b1, 32'd9, 32'd3, C_SLL, 5'd2, 1'b1, 1'b0);
        applyStimulus({20'h12345, 5'd6, 7'b0110111}, 32'd11, 32'd22);
        checkSlot("lui", 1'b1, 32'd0, 32'h1234_5000, C_CPY, 5'd6, 1'b1, 1'b0);
        applyStimulus({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011}, 32'd5, 32'd7);
        checkSlot("branch", 1'b1, 32'd0, 32'd0, C_ADD, 5'd0, 1'b0, 1'b1);
        applyStimulus(r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7);
        checkSlot("bad_f7", 1'b1, 32'd0, 32'd0, C_ADD, 5'd0, 1'b0, 1'b1);
        applyStimulus(i_type({7'b0100000, 5'd3}, 5'd1, 3'b001, 5'd2), 32'd9, 32'd0);
        checkSlot("bad_slli", 1'b1, 32'd0, 32'd0, C_ADD, 5'd0, 1'b0, 1'b1);
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7);
        checkSlot("rd_x0", 1'b1, 32'd5, 32'd7, C_ADD, 5'd0, 1'b1, 1'b0);

        bus.fwd_we = 1'b1;  bus.fwd_rd = 5'd1;  bus.fwd_data = 32'd99;
        applyStimulus(r_type(7'b0, 5'd1, 5'd1, 3'b000, 5'd3), 32'd1, 32'd1);
        checkSlot("fwd", 1'b1, 32'd99, 32'd99, C_ADD, 5'd3, 1'b1, 1'b0);
        bus.fwd_rd = 5'd0;
        applyStimulus(r_type(7'b0, 5'd0, 5'd0, 3'b000, 5'd3), 32'd55, 32'd55);
        checkSlot("fwd_x0", 1'b1, 32'd0, 32'd0, C_ADD, 5'd3, 1'b1, 1'b0);
        bus.fwd_rd = 5'd2;  bus.fwd_data = 32'd50;
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd4, 32'd6);
        checkSlot("fwd_rs2", 1'b1, 32'd4, 32'd50, C_ADD, 5'd3, 1'b1, 1'b0);
        bus.fwd_we = 1'b0;  bus.fwd_rd = 5'd1;
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd4, 32'd6);
        checkSlot("fwd_off", 1'b1, 32'd4, 32'd6, C_ADD, 5'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("bubble.valid", 32'(bus.out_valid), 32'd0);

        // Stall: the queued XOR must wait behind the held ADD and appear once.
        bus.out_ready = 1'b0;
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd10), 32'd1, 32'd2);
        bus.in_valid = 1'b1;
        bus.instr    = r_type(7'b0, 5'd4, 5'd3, 3'b100, 5'd11);
        bus.rs1_data = 32'd3;
        bus.rs2_data = 32'd4;
        #1;
        checkOutput("stall.in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkSlot($sformatf("stall%0d", i), 1'b1, 32'd1, 32'd2, C_ADD, 5'd10, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkSlot("queued", 1'b1, 32'd3, 32'd4, C_XOR, 5'd11, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("drain.valid", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        applyStimulus(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd12), 32'd1, 32'd1);
        checkOutput("held.valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.instr    = r_type(7'b0, 5'd2, 5'd1, 3'b110, 5'd13);
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_held.valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_drop.valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_empty.valid", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        applyStimulus({20'h12345, 5'd6, 7'b0110111}, 32'd0, 32'd0);
        checkSlot("pre_rst", 1'b1, 32'd0, 32'h1234_5000, C_CPY, 5'd6, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkSlot("mid_rst", 1'b0, 32'h0, 32'h0, C_ADD, 5'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
